// File: rtl/mips_core_pkg.sv
// Shared core types: branch outcome plus the branch target buffer entry and sweep-state types.
// The stored tag field is sized for the smallest legal table; narrower tags are zero-extended.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

package mips_core_pkg;

  typedef enum logic {
    NOT_TAKEN = 1'b0,
    TAKEN     = 1'b1
  } BranchOutcome;

  localparam int unsigned BTB_TAG_W = `ADDR_WIDTH - 2;

  typedef struct packed {
    logic                   valid;
    logic [BTB_TAG_W-1:0]   tag;
    logic [`ADDR_WIDTH-1:0] target;
    logic [1:0]             ctr;
    logic                   is_jump;
  } btb_entry_t;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } btb_state_e;

endpackage

// File: rtl/btb_ctr_next.sv
// Two-bit saturating direction counter next state; jumps pin the counter at strongly taken.
module btb_ctr_next
  import mips_core_pkg::*;
(
  input  logic [1:0]   ctr,
  input  BranchOutcome outcome,
  input  logic         is_jump,
  output logic [1:0]   ctr_next
);

  always_comb begin
    ctr_next = ctr;
    if (is_jump) begin
      ctr_next = 2'b11;
    end else if (outcome == TAKEN) begin
      if (ctr != 2'b11) ctr_next = ctr + 2'd1;
    end else begin
      if (ctr != 2'b00) ctr_next = ctr - 2'd1;
    end
  end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped fetch-stage BTB with same-cycle lookup, EX-stage training and a clear sweep.
// Optional lookup/hit counters are built when BTB_STATS_EN is defined.
module branch_target_buffer
  import mips_core_pkg::*;
#(
  parameter int unsigned ENTRIES    = 16,
  parameter int unsigned INDEX_BITS = $clog2(ENTRIES),
  parameter int unsigned TAG_WIDTH  = `ADDR_WIDTH - INDEX_BITS - 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_lookup_valid,
  input  logic [`ADDR_WIDTH-1:0] i_lookup_pc,
  output logic                   o_hit,
  output logic                   o_pred_taken,
  output logic [`ADDR_WIDTH-1:0] o_pred_target,
  output logic                   o_ready,
  input  logic                   i_update_valid,
  input  logic [`ADDR_WIDTH-1:0] i_update_pc,
  input  logic [`ADDR_WIDTH-1:0] i_update_target,
  input  BranchOutcome           i_update_outcome,
  input  logic                   i_update_is_jump,
  input  logic                   i_flush
`ifdef BTB_STATS_EN
  ,
  output logic [31:0]            o_stat_lookups,
  output logic [31:0]            o_stat_hits
`endif
);

  btb_entry_t            table_q [ENTRIES];
  btb_state_e            state_q;
  logic [INDEX_BITS-1:0] sweep_idx_q;
  logic                  ready;

  logic [INDEX_BITS-1:0] lk_idx, up_idx;
  logic [TAG_WIDTH-1:0]  lk_tag, up_tag;
  btb_entry_t            lk_e, up_e, up_new;
  logic                  up_hit, up_en, up_write;
  logic [1:0]            up_ctr_next;
  logic                  unused_pc_bits;

  assign ready   = (state_q == READY);
  assign o_ready = ready;

  assign lk_idx = i_lookup_pc[INDEX_BITS+1:2];
  assign lk_tag = i_lookup_pc[`ADDR_WIDTH-1:INDEX_BITS+2];
  assign up_idx = i_update_pc[INDEX_BITS+1:2];
  assign up_tag = i_update_pc[`ADDR_WIDTH-1:INDEX_BITS+2];
  assign lk_e   = table_q[lk_idx];
  assign up_e   = table_q[up_idx];

  assign unused_pc_bits = ^{i_lookup_pc[1:0], i_update_pc[1:0]};

  always_comb begin
    o_hit         = ready & i_lookup_valid & lk_e.valid & (lk_e.tag == BTB_TAG_W'(lk_tag));
    o_pred_taken  = o_hit & (lk_e.ctr[1] | lk_e.is_jump);
    o_pred_target = o_hit ? lk_e.target : '0;
  end

  btb_ctr_next u_ctr_next (
    .ctr      (up_e.ctr),
    .outcome  (i_update_outcome),
    .is_jump  (i_update_is_jump),
    .ctr_next (up_ctr_next)
  );

  // Flush and reset both beat a same-cycle update.
  always_comb begin
    up_hit        = up_e.valid & (up_e.tag == BTB_TAG_W'(up_tag));
    up_en         = i_update_valid & ready & ~i_flush & ~rst;
    up_new        = up_e;
    up_new.target = i_update_target;
    up_write      = 1'b0;
    if (up_hit) begin
      up_new.ctr     = up_ctr_next;
      up_new.is_jump = up_e.is_jump | i_update_is_jump;
      up_write       = up_en;
    end else if ((i_update_outcome == TAKEN) || i_update_is_jump) begin
      up_new.valid   = 1'b1;
      up_new.tag     = BTB_TAG_W'(up_tag);
      up_new.ctr     = i_update_is_jump ? 2'b11 : 2'b10;
      up_new.is_jump = i_update_is_jump;
      up_write       = up_en;
    end
  end

  // Entry payloads are never reset; only the sweep clears valid bits.
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      table_q[sweep_idx_q].valid <= 1'b0;
    end else if (up_write) begin
      table_q[up_idx] <= up_new;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      state_q     <= CLEAR;
      sweep_idx_q <= '0;
    end else if (state_q == CLEAR) begin
      if (sweep_idx_q == INDEX_BITS'(ENTRIES - 1)) begin
        state_q <= READY;
      end else begin
        sweep_idx_q <= sweep_idx_q + INDEX_BITS'(1);
      end
    end
  end

`ifdef BTB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      o_stat_lookups <= '0;
      o_stat_hits    <= '0;
    end else begin
      if (ready & i_lookup_valid) o_stat_lookups <= o_stat_lookups + 32'd1;
      if (o_hit)                  o_stat_hits    <= o_stat_hits + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed self-checking bench for branch_target_buffer with ENTRIES=16.
module tb_branch_target_buffer;
  import mips_core_pkg::*;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   lookup_valid;
  logic [`ADDR_WIDTH-1:0] lookup_pc;
  logic                   hit, pred_taken, ready;
  logic [`ADDR_WIDTH-1:0] pred_target;
  logic                   update_valid;
  logic [`ADDR_WIDTH-1:0] update_pc, update_target;
  BranchOutcome           update_outcome;
  logic                   update_is_jump;
  logic                   flush;
`ifdef BTB_STATS_EN
  logic [31:0]            stat_lookups, stat_hits;
`endif

  int n_tests     = 0;
  int n_fail      = 0;
  int exp_lookups = 0;
  int exp_hits    = 0;

  branch_target_buffer #(.ENTRIES(16)) dut (
    .clk              (clk),
    .rst              (rst),
    .i_lookup_valid   (lookup_valid),
    .i_lookup_pc      (lookup_pc),
    .o_hit            (hit),
    .o_pred_taken     (pred_taken),
    .o_pred_target    (pred_target),
    .o_ready          (ready),
    .i_update_valid   (update_valid),
    .i_update_pc      (update_pc),
    .i_update_target  (update_target),
    .i_update_outcome (update_outcome),
    .i_update_is_jump (update_is_jump),
    .i_flush          (flush)
`ifdef BTB_STATS_EN
    ,
    .o_stat_lookups   (stat_lookups),
    .o_stat_hits      (stat_hits)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Lookup in READY: check outputs mid-cycle, then let the edge count it.
  task automatic lookup(input logic [31:0] pc, input logic eh, input logic et,
                        input logic [31:0] etgt, input string tag);
    lookup_valid = 1'b1;
    lookup_pc    = pc;
    #3;
    check({tag, "_hit"}, 32'(hit), 32'(eh));
    check({tag, "_taken"}, 32'(pred_taken), 32'(et));
    check({tag, "_target"}, pred_target, etgt);
    exp_lookups++;
    if (eh) exp_hits++;
    tick();
    lookup_valid = 1'b0;
  endtask

  task automatic update(input logic [31:0] pc, input logic [31:0] tgt,
                        input BranchOutcome oc, input logic jmp);
    update_valid   = 1'b1;
    update_pc      = pc;
    update_target  = tgt;
    update_outcome = oc;
    update_is_jump = jmp;
    tick();
    update_valid   = 1'b0;
    update_is_jump = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    lookup_valid   = 1'b0;
    lookup_pc      = '0;
    update_valid   = 1'b0;
    update_pc      = '0;
    update_target  = '0;
    update_outcome = NOT_TAKEN;
    update_is_jump = 1'b0;
    flush          = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    lookup_valid = 1'b1;
    lookup_pc    = 32'h0040_0010;
    #3;
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_hit", 32'(hit), 32'd0);
    check("rst_taken", 32'(pred_taken), 32'd0);
    check("rst_target", pred_target, 32'd0);
`ifdef BTB_STATS_EN
    check("rst_stat_lookups", stat_lookups, 32'd0);
    check("rst_stat_hits", stat_hits, 32'd0);
`endif
    rst          = 1'b0;
    lookup_valid = 1'b0;

    // Case 1: sweep after reset, then a cold miss.
    for (int i = 1; i <= 16; i++) begin
      tick();
      check($sformatf("c1_ready_%0d", i), 32'(ready), (i == 16) ? 32'd1 : 32'd0);
    end
    lookup(32'h0040_0010, 1'b0, 1'b0, 32'h0, "c1_cold");

    // Case 2: taken allocation (ctr=10).
    update(32'h0040_0010, 32'h0040_0100, TAKEN, 1'b0);
    lookup(32'h0040_0010, 1'b1, 1'b1, 32'h0040_0100, "c2_alloc");

    // Case 3: 10 -> 01 -> 00 -> 00 (saturate) -> 01 -> 10.
    update(32'h0040_0010, 32'h0040_0100, NOT_TAKEN, 1'b0);
    lookup(32'h0040_0010, 1'b1, 1'b0, 32'h0040_0100, "c3_nt1");
    update(32'h0040_0010, 32'h0040_0100, NOT_TAKEN, 1'b0);
    lookup(32'h0040_0010, 1'b1, 1'b0, 32'h0040_0100, "c3_nt2");
    update(32'h0040_0010, 32'h0040_0100, NOT_TAKEN, 1'b0);
    lookup(32'h0040_0010, 1'b1, 1'b0, 32'h0040_0100, "c3_sat");
    update(32'h0040_0010, 32'h0040_0100, TAKEN, 1'b0);
    lookup(32'h0040_0010, 1'b1, 1'b0, 32'h0040_0100, "c3_t1");
    update(32'h0040_0010, 32'h0040_0100, TAKEN, 1'b0);
    lookup(32'h0040_0010, 1'b1, 1'b1, 32'h0040_0100, "c3_t2");

    // Case 4: conflict at index 4 replaces the old tag; not-taken miss allocates nothing.
    update(32'h0040_0050, 32'h0040_0200, TAKEN, 1'b0);
    lookup(32'h0040_0050, 1'b1, 1'b1, 32'h0040_0200, "c4_new");
    lookup(32'h0040_0010, 1'b0, 1'b0, 32'h0, "c4_evicted");
    update(32'h0040_0020, 32'h0040_0400, NOT_TAKEN, 1'b0);
    lookup(32'h0040_0020, 1'b0, 1'b0, 32'h0, "c4_nt_noalloc");

    // Case 5: jump; same-cycle lookup sees the old (empty) entry.
    update_valid   = 1'b1;
    update_pc      = 32'h0040_0030;
    update_target  = 32'h0040_0300;
    update_outcome = TAKEN;
    update_is_jump = 1'b1;
    lookup_valid   = 1'b1;
    lookup_pc      = 32'h0040_0030;
    #3;
    check("c5_same_cycle_hit", 32'(hit), 32'd0);
    exp_lookups++;
    tick();
    update_valid   = 1'b0;
    update_is_jump = 1'b0;
    lookup_valid   = 1'b0;
    lookup(32'h0040_0030, 1'b1, 1'b1, 32'h0040_0300, "c5_jump");
    update(32'h0040_0030, 32'h0040_0300, NOT_TAKEN, 1'b0);
    update(32'h0040_0030, 32'h0040_0300, NOT_TAKEN, 1'b0);
    lookup(32'h0040_0030, 1'b1, 1'b1, 32'h0040_0300, "c5_jump_sticky");

    // Case 6: flush with a same-cycle update, re-flush at sweep cycle 5.
    flush          = 1'b1;
    update_valid   = 1'b1;
    update_pc      = 32'h0040_0020;
    update_target  = 32'h0040_0500;
    update_outcome = TAKEN;
    tick();
    flush        = 1'b0;
    update_valid = 1'b0;
    lookup_valid = 1'b1;
    lookup_pc    = 32'h0040_0030;
    for (int i = 0; i <= 5; i++) begin
      if (i != 0) tick();
      check($sformatf("c6_sweep_ready_%0d", i), 32'(ready), 32'd0);
      check($sformatf("c6_sweep_hit_%0d", i), 32'(hit), 32'd0);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      check($sformatf("c6_reflush_ready_%0d", i), 32'(ready), (i == 16) ? 32'd1 : 32'd0);
      check($sformatf("c6_reflush_hit_%0d", i), 32'(hit), 32'd0);
    end
    lookup_valid = 1'b0;
    lookup(32'h0040_0030, 1'b0, 1'b0, 32'h0, "c6_cleared");
    lookup(32'h0040_0020, 1'b0, 1'b0, 32'h0, "c6_update_dropped");

`ifdef BTB_STATS_EN
    check("stat_lookups", stat_lookups, 32'(exp_lookups));
    check("stat_hits", stat_hits, 32'(exp_hits));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
